// File: rtl/bcd_down_count.sv
// Multi-digit BCD countdown timer: clamped parallel load, per-digit borrow ripple,
// zero detect, one-cycle terminal pulse and optional auto-reload of the last loaded value.
module bcd_down_count #(
  parameter int DIGITS      = 3,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   num,
  output logic                  zero,
  output logic                  done,
  output logic                  running
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_d;
  logic [W-1:0]   reload, reload_d, num_d;
  logic [W-1:0]   load_clamped, num_dec;
  logic           done_d;

  // Digits above 9 are forced to 9 so the counter never holds an illegal BCD code.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int d = 0; d < DIGITS; d++)
      r[4*d +: 4] = (v[4*d +: 4] > 4'd9) ? 4'd9 : v[4*d +: 4];
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    borrow = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (!borrow) begin
        r[4*d +: 4] = v[4*d +: 4];
      end else if (v[4*d +: 4] == 4'd0) begin
        r[4*d +: 4] = 4'd9;
      end else begin
        r[4*d +: 4] = v[4*d +: 4] - 4'd1;
        borrow      = 1'b0;
      end
    end
    return r;
  endfunction

  assign load_clamped = clamp_bcd(load_val);
  assign num_dec      = bcd_dec(num);

  always_comb begin
    state_d  = state;
    num_d    = num;
    reload_d = reload;
    done_d   = 1'b0;
    if (load) begin
      num_d    = load_clamped;
      reload_d = load_clamped;
      state_d  = (load_clamped != '0) ? RUN : IDLE;
    end else begin
      case (state)
        RUN: begin
          if (en) begin
            num_d = num_dec;
            if (num_dec == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        DONE: begin
          // A zero reload value cannot restart the count; stay parked at zero.
          if (AUTO_RELOAD && en && reload != '0) begin
            num_d   = reload;
            state_d = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  // Flags are registered from the next-state values so they line up with num/state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      num     <= '0;
      reload  <= '0;
      zero    <= 1'b1;
      done    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_d;
      num     <= num_d;
      reload  <= reload_d;
      zero    <= (num_d == '0);
      done    <= done_d;
      running <= (state_d == RUN);
    end
  end

endmodule

// File: tb/tb_bcd_down_count.sv
// Bench for bcd_down_count: three builds (3-digit stop, 3-digit auto-reload, 4-digit stop)
// share stimulus and are compared each cycle against a decimal-arithmetic reference model.
module tb_bcd_down_count;

  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;

  logic        clk, rst, load, en;
  logic [15:0] lv;
  logic [11:0] num0, num1;
  logic [15:0] num2;
  logic        zero0, zero1, zero2, done0, done1, done2, run0, run1, run2;

  int passes = 0, checks = 0;
  int m_val[3], m_rel[3], m_st[3], m_done[3];
  int dig[3] = '{3, 3, 4};
  bit aut[3] = '{1'b0, 1'b1, 1'b0};

  bcd_down_count #(.DIGITS(3), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .load_val(lv[11:0]), .en(en),
    .num(num0), .zero(zero0), .done(done0), .running(run0));
  bcd_down_count #(.DIGITS(3), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_val(lv[11:0]), .en(en),
    .num(num1), .zero(zero1), .done(done1), .running(run1));
  bcd_down_count #(.DIGITS(4), .AUTO_RELOAD(1'b0)) dut2 (
    .clk(clk), .rst(rst), .load(load), .load_val(lv), .en(en),
    .num(num2), .zero(zero2), .done(done2), .running(run2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] obs_num(int i);
    if (i == 0) return {4'h0, num0};
    if (i == 1) return {4'h0, num1};
    return num2;
  endfunction

  function automatic logic [2:0] obs_flg(int i);
    if (i == 0) return {zero0, done0, run0};
    if (i == 1) return {zero1, done1, run1};
    return {zero2, done2, run2};
  endfunction

  // Reference model: the count is kept as a plain decimal integer.
  function automatic int sanitise(logic [15:0] v, int n);
    int val = 0, p = 1;
    for (int d = 0; d < n; d++) begin
      int nib = int'(v[4*d +: 4]);
      val += ((nib > 9) ? 9 : nib) * p;
      p *= 10;
    end
    return val;
  endfunction

  function automatic logic [15:0] to_bcd(int val, int n);
    logic [15:0] r = '0;
    int p = 1;
    for (int d = 0; d < n; d++) begin
      r[4*d +: 4] = 4'((val / p) % 10);
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] exp_num(int i);
    return to_bcd(m_val[i], dig[i]);
  endfunction

  function automatic logic [2:0] exp_flg(int i);
    return {m_val[i] == 0, m_done[i] != 0, m_st[i] == S_RUN};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_val[i] = 0; m_rel[i] = 0; m_st[i] = S_IDLE; m_done[i] = 0;
    end
  endtask

  task automatic model_step(input logic ld, input logic [15:0] v, input logic e);
    for (int i = 0; i < 3; i++) begin
      m_done[i] = 0;
      if (ld) begin
        m_val[i] = sanitise(v, dig[i]);
        m_rel[i] = m_val[i];
        m_st[i]  = (m_val[i] != 0) ? S_RUN : S_IDLE;
      end else if (m_st[i] == S_RUN && e) begin
        m_val[i] -= 1;
        if (m_val[i] == 0) begin
          m_st[i] = S_DONE; m_done[i] = 1;
        end
      end else if (m_st[i] == S_DONE && e && aut[i]) begin
        m_val[i] = m_rel[i];
        m_st[i]  = S_RUN;
      end
    end
  endtask

  task automatic drive(input logic ld, input logic [15:0] v, input logic e);
    @(negedge clk);
    load = ld; lv = v; en = e;
    @(posedge clk);
    model_step(ld, v, e);
    #1;
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_num(i) !== exp_num(i))
        $display("FAIL reset_num inst%0d got %h expected %h", i, obs_num(i), exp_num(i));
      else passes++;
      checks++;
      if (obs_flg(i) !== exp_flg(i))
        $display("FAIL reset_flags inst%0d {zero,done,running} got %b expected %b", i, obs_flg(i), exp_flg(i));
      else passes++;
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk) model_step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 16'h0125, 1'b0);
    repeat (3) drive(1'b0, 16'h0, 1'b1);
    en = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_num(i) !== exp_num(i) || obs_flg(i) !== exp_flg(i))
        $display("FAIL async_reset inst%0d num/flags got %h/%b expected %h/%b",
                 i, obs_num(i), obs_flg(i), exp_num(i), exp_flg(i));
      else passes++;
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk) model_step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_borrow();
    logic [15:0] vec [6] = '{16'h0100, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0000};
    logic        ldv [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        env [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      drive(ldv[k], vec[k], env[k]);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_num(i) !== exp_num(i))
          $display("FAIL borrow_num step%0d inst%0d got %h expected %h", k, i, obs_num(i), exp_num(i));
        else passes++;
        checks++;
        if (obs_flg(i) !== exp_flg(i))
          $display("FAIL borrow_flags step%0d inst%0d got %b expected %b", k, i, obs_flg(i), exp_flg(i));
        else passes++;
      end
    end
  endtask

  task automatic test_terminal();
    int pulses = 0;
    drive(1'b1, 16'h0003, 1'b0);
    for (int k = 0; k < 13; k++) begin
      drive(1'b0, 16'h0, 1'b1);
      pulses += int'(done0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_num(i) !== exp_num(i))
          $display("FAIL terminal_num cyc%0d inst%0d got %h expected %h", k, i, obs_num(i), exp_num(i));
        else passes++;
        checks++;
        if (obs_flg(i) !== exp_flg(i))
          $display("FAIL terminal_flags cyc%0d inst%0d got %b expected %b", k, i, obs_flg(i), exp_flg(i));
        else passes++;
      end
    end
    checks++;
    if (pulses !== 1) $display("FAIL terminal_pulses got %0d expected 1", pulses);
    else passes++;
  endtask

  task automatic test_priority();
    logic [15:0] vec [5] = '{16'h0050, 16'h02BF, 16'h0000, 16'h0000, 16'h0000};
    logic        ldv [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        env [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      drive(ldv[k], vec[k], env[k]);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_num(i) !== exp_num(i))
          $display("FAIL priority_num step%0d inst%0d got %h expected %h", k, i, obs_num(i), exp_num(i));
        else passes++;
        checks++;
        if (obs_flg(i) !== exp_flg(i))
          $display("FAIL priority_flags step%0d inst%0d got %b expected %b", k, i, obs_flg(i), exp_flg(i));
        else passes++;
      end
    end
  endtask

  task automatic test_auto_reload();
    int pulses = 0;
    drive(1'b1, 16'h0002, 1'b0);
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 16'h0, 1'b1);
      pulses += int'(done1);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_num(i) !== exp_num(i) || obs_flg(i) !== exp_flg(i))
          $display("FAIL auto_reload cyc%0d inst%0d num/flags got %h/%b expected %h/%b",
                   k, i, obs_num(i), obs_flg(i), exp_num(i), exp_flg(i));
        else passes++;
      end
    end
    checks++;
    if (pulses !== 2) $display("FAIL auto_reload_pulses got %0d expected 2", pulses);
    else passes++;
  endtask

  task automatic test_four_digit();
    drive(1'b1, 16'h1000, 1'b0);
    for (int k = 0; k < 17; k++) begin
      drive(1'b0, 16'h0, (k % 4) == 0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_num(i) !== exp_num(i) || obs_flg(i) !== exp_flg(i))
          $display("FAIL four_digit cyc%0d inst%0d num/flags got %h/%b expected %h/%b",
                   k, i, obs_num(i), obs_flg(i), exp_num(i), exp_flg(i));
        else passes++;
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      logic        ld = ($urandom_range(0, 11) == 0);
      logic [15:0] v  = $urandom_range(0, 1) ? 16'($urandom_range(0, 6)) : 16'($urandom);
      logic        e  = ($urandom_range(0, 3) != 0);
      drive(ld, v, e);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_num(i) !== exp_num(i) || obs_flg(i) !== exp_flg(i))
          $display("FAIL random cyc%0d inst%0d num/flags got %h/%b expected %h/%b",
                   k, i, obs_num(i), obs_flg(i), exp_num(i), exp_flg(i));
        else passes++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0; lv = '0;
    model_reset();
    test_reset();
    test_async_reset();
    test_borrow();
    test_terminal();
    test_priority();
    test_auto_reload();
    test_four_digit();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bcd_down_count.md
Name: bcd_down_count

Overview:
- Multi-digit BCD down-counter (countdown timer): the count-down counterpart of the team's 3-digit BCD up-counter.
- Per-digit borrow chaining, parallel BCD load, zero detect and one-cycle terminal pulse.
- Drives the same 12-bit BCD display bus format: digit 0 in bits [3:0], digit 1 in [7:4], digit 2 in [11:8].
- Sits between the switch/button conditioning logic and the display path.

Parameters:
- DIGITS, 3, number of BCD digits; count bus width is 4*DIGITS.
- AUTO_RELOAD, 0, 1 = after reaching zero, the next enabled tick reloads the last loaded value and keeps running; 0 = stop at zero.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  capture load_val on the next rising edge; has priority over en.
- load_val  input  4*DIGITS  BCD preset value.
- en  input  1  count-down tick enable, sampled every rising edge.
- num  output  4*DIGITS  current BCD count, registered.
- zero  output  1  high whenever num == 0, registered.
- done  output  1  one-cycle pulse when a running count reaches zero.
- running  output  1  high in state RUN.

Behaviour:
- Reset (async, any time, including mid-count):
  - num = 0, reload register = 0, state = IDLE.
  - zero = 1, done = 0, running = 0.
  - Release is synchronous to the next clk edge; no count happens on the release edge unless en/load are sampled high there.
- Load sanitising: any digit of load_val greater than 9 is clamped to 9 before storing. Example: 0x3A7 is stored as 0x397.
- States: IDLE, RUN, DONE.
- IDLE:
  - load=1: num <= sanitised load_val and the reload register is updated.
  - Next state is RUN if the value is nonzero, otherwise IDLE.
  - en is ignored in IDLE.
- RUN, load=1: reload as in IDLE. The load wins over a same-cycle en; no decrement that cycle.
- RUN, en=1, load=0:
  - Decrement by one with BCD borrow ripple.
  - Digit 0 decrements; a digit at 0 wraps to 9 and borrows from the next digit; the borrow propagates through all digits in the same cycle.
  - Single-cycle latency: num reflects the decrement after the edge on which en was sampled high.
  - If the new value is 0: next state DONE, and done = 1 for exactly the cycle following that edge.
- RUN, en=0: hold.
- DONE:
  - num holds 0; zero = 1; done = 0 after its single pulse.
  - load=1 behaves as in IDLE.
  - AUTO_RELOAD=1, en=1, load=0: num <= reload register, state RUN. That reload edge is not itself a decrement.
  - AUTO_RELOAD=0: en is ignored; the block stays in DONE until load or reset.
- Never underflows: there is no transition from 0 to 9…9.
- zero and running are registered and consistent with num/state in the same cycle.
- done never asserts for loads of 0, for holds, or for reset.

Test Plan:
- Reset mid-count: load 0x125, run 3 ticks, assert rst asynchronously between edges -> num=0x000, zero=1, running=0 immediately, before the next clk edge.
- Borrow ripple: load 0x100, one en tick -> num=0x099. Next tick -> 0x098. Load 0x010, one tick -> 0x009.
- Terminal count: load 0x003, en held high -> num goes 0x002, 0x001, 0x000. done=1 for exactly one cycle with num=0x000. DONE state holds 0x000 for 10 further enabled cycles; done stays 0 and there is no wrap to 0x999.
- Priority and clamping: in RUN at 0x050, assert load=1 with load_val=0x2BF and en=1 in the same cycle -> num=0x299 next cycle, no decrement applied. Loading 0x000 -> IDLE, zero=1, done never pulses.
- Auto reload: with AUTO_RELOAD=1, load 0x002 and hold en -> sequence 0x001, 0x000 (done pulse), 0x002, 0x001, 0x000 (done pulse). Exactly 2 done pulses in 6 enabled cycles.
- DIGITS=4 build: load 0x1000, one tick -> 0x0999. Gapped en (1 of every 4 cycles) decrements only on enabled edges.
